// File: rtl/uart_rx_buffer_writer.sv
// uart_rx_buffer_writer: claims a buffer from the circular buffer controller, fills it from a UART byte stream, pads on idle timeout, hands it back
// Ports:
//   clk_i, rst_n_i                       clock, asynchronous active-low reset
//   s_data_i, s_valid_i, s_ready_o       incoming byte stream (accept on valid && ready)
//   ovf_o                                pulse for each byte presented while not ready (byte dropped)
//   wr_req_o, wr_req_ack_i, wr_req_result_i        buffer claim handshake
//   wr_finish_o, wr_finish_ack_i                   buffer hand-back handshake
//   wr_en_o, wr_data_o, wr_addr_o                  write port into the claimed buffer
//   frame_cnt_o                          number of committed buffers (wrapping)
module uart_rx_buffer_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RETRY_GAP = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic                  ovf_o,
    output logic                  wr_req_o,
    input  logic                  wr_req_ack_i,
    input  logic                  wr_req_result_i,
    output logic                  wr_finish_o,
    input  logic                  wr_finish_ack_i,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [15:0]           frame_cnt_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(RETRY_GAP + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] GAP_LAST = BW'(RETRY_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, REQ_RELEASE, BACKOFF, WRITE, PAD, FINISH, FINISH_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic [BW-1:0]         bo_q, bo_d;
    logic                  res_q, res_d;
    logic                  s_ready_q, s_ready_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_req_q, wr_req_d;
    logic                  wr_finish_q, wr_finish_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           frame_q, frame_d;
    logic                  accept;

    assign accept = s_valid_i && s_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        bo_d      = bo_q;
        res_d     = res_q;
        frame_d   = frame_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        ovf_d     = s_valid_i && !s_ready_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (wr_req_ack_i) begin
                    res_d   = wr_req_result_i;
                    state_d = REQ_RELEASE;
                end
            end
            REQ_RELEASE: begin
                if (!wr_req_ack_i) begin
                    state_d = res_q ? WRITE : BACKOFF;
                    cnt_d   = '0;
                    idle_d  = '0;
                    bo_d    = '0;
                end
            end
            BACKOFF: begin
                if (bo_q == GAP_LAST) state_d = REQ;
                else bo_d = bo_q + 1'b1;
            end
            WRITE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = s_data_i;
                    wr_addr_d = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    idle_d    = '0;
                    if (cnt_q == LAST) state_d = FINISH;
                end else if (cnt_q != '0) begin
                    // the current cycle is the TIMEOUT_CYCLES-th idle one when the timer already holds TIMEOUT_CYCLES-1
                    if (idle_q >= TMO_LAST) begin
                        idle_d  = TMO;
                        state_d = PAD;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            PAD: begin
                wr_en_d   = 1'b1;
                wr_data_d = PAD_BYTE;
                wr_addr_d = cnt_q;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = FINISH;
            end
            // wr_finish_o only rises once FINISH is entered, so it trails the last write by a cycle
            FINISH: if (wr_finish_q && wr_finish_ack_i) state_d = FINISH_RELEASE;
            FINISH_RELEASE: begin
                if (!wr_finish_ack_i) begin
                    frame_d = frame_q + 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d   = state_d == WRITE;
        wr_req_d    = state_d == REQ;
        wr_finish_d = state_q == FINISH && state_d == FINISH;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            bo_q        <= '0;
            res_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_finish_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            bo_q        <= bo_d;
            res_q       <= res_d;
            s_ready_q   <= s_ready_d;
            ovf_q       <= ovf_d;
            wr_req_q    <= wr_req_d;
            wr_finish_q <= wr_finish_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            frame_q     <= frame_d;
        end
    end

    assign s_ready_o   = s_ready_q;
    assign ovf_o       = ovf_q;
    assign wr_req_o    = wr_req_q;
    assign wr_finish_o = wr_finish_q;
    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_cnt_o = frame_q;
endmodule

// File: tb/tb_uart_rx_buffer_writer.sv
// tb_uart_rx_buffer_writer: randomized bench with a transaction-level model of the buffer writer and a scripted controller
module tb_uart_rx_buffer_writer;
    localparam int DEPTH = 256;
    localparam int TMO = 1000;
    localparam int GAP = 16;
    localparam logic [7:0] PADB = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        req_ack = 1'b0;
    logic        req_res = 1'b0;
    logic        fin_ack = 1'b0;
    logic        s_ready_o, ovf_o, wr_req_o, wr_finish_o, wr_en_o;
    logic [7:0]  wr_data_o, wr_addr_o;
    logic [15:0] frame_cnt_o;

    uart_rx_buffer_writer #(
        .DATA_WIDTH(8), .DATA_DEPTH(DEPTH), .ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(TMO), .RETRY_GAP(GAP), .PAD_BYTE(PADB)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready_o), .ovf_o(ovf_o),
        .wr_req_o(wr_req_o), .wr_req_ack_i(req_ack), .wr_req_result_i(req_res),
        .wr_finish_o(wr_finish_o), .wr_finish_ack_i(fin_ack),
        .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .wr_addr_o(wr_addr_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    bit exp_ready, exp_ovf, exp_wen, exp_req, exp_fin;
    bit pad_on, pend_inc, start, grant_wait, granted;
    int cnt, idle, bo_left, fin_st, cyc;
    logic [7:0] exp_addr, exp_data;
    logic [15:0] exp_frame;
    bit script[$];
    bit only_ready, data_inc, prev_req;
    int lim, v_prob, fin_hold, fin_hold_cfg;
    int req_rises = 0, obs_wen = 0, ovf_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_s_ready"}, 32'(s_ready_o), 0);
        chk({p, "_ovf"}, 32'(ovf_o), 0);
        chk({p, "_wr_req"}, 32'(wr_req_o), 0);
        chk({p, "_wr_finish"}, 32'(wr_finish_o), 0);
        chk({p, "_wr_en"}, 32'(wr_en_o), 0);
        chk({p, "_wr_data"}, 32'(wr_data_o), 0);
        chk({p, "_wr_addr"}, 32'(wr_addr_o), 0);
        chk({p, "_frame_cnt"}, 32'(frame_cnt_o), 0);
    endtask

    task automatic model_reset();
        exp_ready = 0; exp_ovf = 0; exp_wen = 0; exp_req = 0; exp_fin = 0;
        pad_on = 0; pend_inc = 0; start = 1; grant_wait = 0; granted = 0;
        cnt = 0; idle = 0; bo_left = 0; fin_st = 0; exp_frame = '0; prev_req = 0;
    endtask

    // Effects of the clock edge that just passed, given the inputs that were applied to it.
    task automatic model_edge();
        bit rdy0;
        rdy0 = exp_ready;
        exp_ovf = s_valid && !rdy0;
        exp_wen = 0;
        if (start) begin
            start = 0;
            exp_req = 1;
        end else if (exp_req && req_ack) exp_req = 0;
        if (bo_left > 0) begin
            bo_left--;
            if (bo_left == 0) exp_req = 1;
        end
        if (grant_wait && !req_ack) begin
            grant_wait = 0;
            if (granted) begin exp_ready = 1; cnt = 0; idle = 0; end
            else bo_left = GAP;
        end
        if (pend_inc && !fin_ack) begin
            pend_inc = 0;
            exp_frame++;
            exp_req = 1;
        end
        if (fin_st == 2 && fin_ack) begin
            exp_fin = 0; fin_st = 0; pend_inc = 1;
        end else if (fin_st == 1) begin
            exp_fin = 1; fin_st = 2;
        end
        if (s_valid && rdy0) begin
            exp_wen = 1; exp_addr = 8'(cnt); exp_data = s_data;
            cnt++; idle = 0;
            if (cnt == DEPTH) begin exp_ready = 0; fin_st = 1; end
        end else if (pad_on) begin
            exp_wen = 1; exp_addr = 8'(cnt); exp_data = PADB;
            cnt++;
            if (cnt == DEPTH) begin pad_on = 0; fin_st = 1; end
        end else if (exp_ready && cnt > 0) begin
            idle++;
            if (idle == TMO) begin exp_ready = 0; pad_on = 1; end
        end
        cyc++;
    endtask

    task automatic check_cycle();
        chk("s_ready", 32'(s_ready_o), 32'(exp_ready));
        chk("ovf", 32'(ovf_o), 32'(exp_ovf));
        chk("wr_en", 32'(wr_en_o), 32'(exp_wen));
        if (exp_wen) begin
            chk("wr_addr", 32'(wr_addr_o), 32'(exp_addr));
            chk("wr_data", 32'(wr_data_o), 32'(exp_data));
        end
        chk("wr_req", 32'(wr_req_o), 32'(exp_req));
        chk("wr_finish", 32'(wr_finish_o), 32'(exp_fin));
        chk("frame_cnt", 32'(frame_cnt_o), 32'(exp_frame));
        chk("req_fin_overlap", 32'(wr_req_o & wr_finish_o), 0);
        if (wr_req_o && !prev_req) req_rises++;
        prev_req = wr_req_o;
        obs_wen += int'(wr_en_o);
        ovf_cnt += int'(ovf_o);
    endtask

    task automatic drive();
        if (!rst_n) begin
            s_valid = 0; s_data = '0; req_ack = 0; req_res = 0; fin_ack = 0; fin_hold = 0;
            return;
        end
        if (wr_req_o && !req_ack && $urandom_range(0, 1) == 1) begin
            granted = script.size() > 0 ? script.pop_front() : 1'b1;
            req_ack = 1; req_res = granted; grant_wait = 1;
        end else if (!wr_req_o && req_ack && $urandom_range(0, 1) == 1) begin
            req_ack = 0; req_res = 1'($urandom);
        end
        if (wr_finish_o && !fin_ack && $urandom_range(0, 1) == 1) begin
            fin_ack = 1; fin_hold = fin_hold_cfg;
        end else if (!wr_finish_o && fin_ack) begin
            if (fin_hold > 0) fin_hold--;
            else fin_ack = 0;
        end
        s_valid = (only_ready ? exp_ready : 1'b1) && (!exp_ready || cnt < lim) &&
                  ($urandom_range(1, 100) <= v_prob);
        s_data = data_inc ? 8'(cnt) : 8'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            model_edge();
            check_cycle();
        end
        drive();
    endtask

    initial begin
        int r0, w0, o0, t_acc, tgt;
        int ns[2];
        model_reset();
        only_ready = 1; data_inc = 1; v_prob = 100; lim = DEPTH; fin_hold_cfg = 0; cyc = 0;
        #1 rst_n = 0;
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1;
        model_reset();

        // full buffer streamed back-to-back
        for (int i = 0; i < 100 && !exp_ready; i++) step();
        chk("grant1_timeout", 32'(exp_ready), 1);
        w0 = obs_wen;
        for (int i = 0; i < 700 && exp_frame != 1; i++) step();
        chk("frame1_timeout", 32'(exp_frame), 1);
        chk("burst_wen_count", 32'(obs_wen - w0), DEPTH);
        chk("frame1_cnt", 32'(frame_cnt_o), 1);

        // ten bytes then idle: padded to full
        for (int i = 0; i < 100 && !exp_ready; i++) step();
        chk("grant2_timeout", 32'(exp_ready), 1);
        script.push_back(0); script.push_back(0); script.push_back(1);
        r0 = req_rises;
        lim = 10;
        for (int i = 0; i < 100 && cnt != 10; i++) step();
        chk("ten_bytes_timeout", 32'(cnt), 10);
        t_acc = cyc; w0 = obs_wen;
        for (int i = 0; i < TMO + 50 && obs_wen == w0; i++) step();
        chk("pad_delay", 32'(cyc - t_acc), TMO + 1);
        for (int i = 0; i < 600 && exp_frame != 2; i++) step();
        chk("frame2_timeout", 32'(exp_frame), 2);
        chk("pad_count", 32'(obs_wen - w0), DEPTH - 10);

        // refused twice, then granted; bytes presented meanwhile overflow
        only_ready = 0; data_inc = 0; v_prob = 60; lim = DEPTH; fin_hold_cfg = 5;
        w0 = obs_wen; o0 = ovf_cnt;
        for (int i = 0; i < 400 && !exp_ready; i++) step();
        chk("grant3_timeout", 32'(exp_ready), 1);
        chk("retry_no_wen", 32'(obs_wen - w0), 0);
        chk("retry_ovf_seen", 32'(ovf_cnt != o0), 1);
        chk("retry_req_pulses", 32'(req_rises - r0), 3);
        for (int i = 0; i < 1500 && exp_frame != 3; i++) step();
        chk("frame3_timeout", 32'(exp_frame), 3);
        fin_hold_cfg = 0;
        repeat (10) step();
        chk("frame_once", 32'(frame_cnt_o), 3);

        // asynchronous reset in the middle of a buffer
        only_ready = 1; data_inc = 1; v_prob = 100; lim = 100;
        for (int i = 0; i < 500 && !(exp_ready && cnt == 100); i++) step();
        chk("mid_write_timeout", 32'(cnt), 100);
        rst_n = 0;
        #1;
        chk_zero("async_rst");
        s_valid = 0; req_ack = 0; req_res = 0; fin_ack = 0; fin_hold = 0;
        model_reset();
        repeat (2) step();
        rst_n = 1;
        lim = DEPTH;
        w0 = obs_wen;
        for (int i = 0; i < 200 && obs_wen == w0; i++) step();
        chk("first_write_seen", 32'(obs_wen != w0), 1);
        chk("addr_after_rst", 32'(wr_addr_o), 0);
        for (int i = 0; i < 700 && exp_frame != 1; i++) step();
        chk("frame_after_rst_timeout", 32'(exp_frame), 1);

        // partial buffers of random length, including one short of full
        only_ready = 0; data_inc = 0; v_prob = 70;
        ns[0] = DEPTH - 1;
        ns[1] = int'($urandom_range(1, DEPTH - 2));
        foreach (ns[k]) begin
            lim = ns[k];
            tgt = int'(exp_frame) + 1;
            for (int i = 0; i < 3000 && int'(exp_frame) != tgt; i++) step();
            chk("pad_frame_timeout", 32'(exp_frame), 32'(tgt));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffer_writer.md
Name: uart_rx_buffer_writer

Overview:
- Sits directly upstream of the circular buffer controller's write port.
- Accepts a byte stream from the UART receiver and claims a free buffer through the request/ack handshake.
- Writes bytes at consecutive in-buffer addresses and hands the buffer back through the finish/ack handshake.
- A buffer closes when it is full, or after an idle timeout. On timeout, the remaining addresses are padded so every committed buffer is complete.

Parameters:
DATA_WIDTH, 8, byte width, equal to the controller's WRITE_DATA_WIDTH
DATA_DEPTH, 256, bytes per buffer, equal to the controller's WRITE_DATA_DEPTH
ADDR_WIDTH, 8, in-buffer address width; must satisfy 2^ADDR_WIDTH >= DATA_DEPTH
TIMEOUT_CYCLES, 1000, idle cycles (no accepted byte) before a partial buffer is padded and closed
RETRY_GAP, 16, back-off cycles after a refused request
PAD_BYTE, 8'h00, fill value for padded addresses

Ports:
clk_i  in  1  clock, same clock as the controller's wr_clk_i
rst_n_i  in  1  asynchronous active-low reset
s_data_i  in  DATA_WIDTH  received byte
s_valid_i  in  1  byte valid
s_ready_o  out  1  byte accepted when s_valid_i && s_ready_o
ovf_o  out  1  one-cycle pulse when s_valid_i && !s_ready_o
wr_req_o  out  1  buffer request, to controller wr_req_i
wr_req_ack_i  in  1  from controller wr_req_ack_o
wr_req_result_i  in  1  1 = buffer granted, 0 = no free buffer
wr_finish_o  out  1  buffer complete, to controller wr_finish_i
wr_finish_ack_i  in  1  from controller wr_finish_ack_o
wr_en_o  out  1  write strobe
wr_data_o  out  DATA_WIDTH  write data
wr_addr_o  out  ADDR_WIDTH  in-buffer address
frame_cnt_o  out  16  committed buffers, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state = IDLE; byte count = 0; idle timer = 0; back-off timer = 0.
  - All outputs 0, including frame_cnt_o.
  - Reset mid-handshake abandons the handshake. The controller must be reset in the same event.
- All outputs are registered.
- State machine:
  - IDLE: next cycle -> REQ. The writer always pre-claims a buffer.
  - REQ: wr_req_o=1. When wr_req_ack_i=1, latch wr_req_result_i, drop wr_req_o -> REQ_RELEASE.
  - REQ_RELEASE: wait for wr_req_ack_i=0.
    - Latched result 1 -> WRITE (count=0, idle timer=0).
    - Latched result 0 -> BACKOFF.
  - BACKOFF: count RETRY_GAP cycles -> REQ.
  - WRITE: s_ready_o=1.
    - On accept: next cycle wr_en_o=1, wr_data_o=s_data_i, wr_addr_o=count; count+1; idle timer cleared.
    - Accept at count = DATA_DEPTH-1 -> FINISH.
    - No accept: idle timer increments only while count>0. At TIMEOUT_CYCLES -> PAD. The timer saturates and never wraps.
  - PAD: s_ready_o=0. One write per cycle, wr_data_o=PAD_BYTE, addresses count..DATA_DEPTH-1. After the last address -> FINISH.
  - FINISH: wr_finish_o rises no earlier than the cycle after the last wr_en_o. Hold it until wr_finish_ack_i=1, then drop it -> FINISH_RELEASE.
  - FINISH_RELEASE: wait for wr_finish_ack_i=0; frame_cnt_o+1 -> REQ.
- s_ready_o is 0 in every state except WRITE.
- ovf_o pulses on every cycle a byte is presented while not ready. Such bytes are dropped and never written.
- wr_en_o is never asserted outside WRITE/PAD. wr_addr_o never exceeds DATA_DEPTH-1.
- Latency: byte accepted at cycle t -> wr_en_o at t+1.
- Simultaneous accept and timeout in the same cycle: the accept wins and the timer clears.
- Request and finish handshakes never overlap: wr_req_o and wr_finish_o are never high together.
- Full buffer with no idle gap: no padding occurs, and the timer is ignored in FINISH.
- Controller full (result 0): retry forever with RETRY_GAP spacing. Bytes arriving meanwhile raise ovf_o.

Test Plan:
- Reset release, controller grants -> wr_req_o high 1 cycle after IDLE; ack+result=1 -> s_ready_o=1 after ack falls; frame_cnt_o=0.
- Stream 256 bytes 0x00..0xFF back-to-back -> wr_en_o 256 cycles, wr_addr_o=wr_data_o=0..255. wr_finish_o asserted then released on ack. frame_cnt_o=1. New wr_req_o follows.
- Send 10 bytes then idle, TIMEOUT_CYCLES=1000 -> 1000 cycles after the 10th accept, PAD writes 0x00 at addresses 10..255 (246 strobes), then finish. frame_cnt_o=1.
- Controller returns result=0 twice then 1, RETRY_GAP=16 -> three wr_req_o pulses separated by 16-cycle gaps. s_ready_o stays 0 until the grant. Bytes presented meanwhile each produce an ovf_o pulse and no wr_en_o.
- Assert rst_n_i low mid-WRITE at count=100 -> all outputs 0 immediately (asynchronously). After release: new request, and the first byte is written at address 0.
- Hold wr_finish_ack_i high 5 extra cycles -> wr_finish_o stays 0. No new wr_req_o until ack falls. frame_cnt_o increments exactly once.
